// File: rtl/lsu_mem_port.sv
// Load/store port: byte/half/word access to a word bus with lanes.
// Define LSU_TIMEOUT_EN to enable the TIMEOUT_CYCLES bus watchdog.
module lsu_mem_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  fn3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] memory_val,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  off, off_q;
  logic        st_q;
  logic        is_byte, is_half, is_word;
  logic        legal, misal, req_ok, accept;
  logic [3:0]  be;
  logic [31:0] wd_sized, wd;
  logic        tmo, tmo_hit;

  assign off = addr[1:0];

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    legal   = 1'b1;
    if (req_is_store) begin
      unique case (fn3)
        3'b000:  is_byte = 1'b1;
        3'b001:  is_half = 1'b1;
        3'b010:  is_word = 1'b1;
        default: legal   = 1'b0;
      endcase
    end else begin
      unique case (fn3)
        3'b001, 3'b100: is_half = 1'b1;
        3'b010:         is_word = 1'b1;
        default:        is_byte = 1'b1;
      endcase
    end
  end

  assign misal  = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign req_ok = (state == IDLE) & req_valid & legal;
  assign accept = req_ok & ~misal;
  assign misalign_err = req_ok & misal;

  always_comb begin
    be       = 4'b1111;
    wd_sized = wdata;
    if (is_byte) begin
      be       = 4'b0001 << off;
      wd_sized = {24'b0, wdata[7:0]};
    end else if (is_half) begin
      be       = 4'b0011 << off;
      wd_sized = {16'b0, wdata[15:0]};
    end
  end

  assign wd = wd_sized << {off, 3'b000};

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt;

  assign tmo = (cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == REQ || state == WAIT_R) begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  // legal range starts at 1, so the watchdog never fires here
  assign tmo = (TIMEOUT_CYCLES == 0);
`endif

  assign tmo_hit = tmo & (((state == REQ) & ~mem_ready) |
                          ((state == WAIT_R) & ~mem_rvalid));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = REQ;
      REQ: begin
        if (mem_ready)  state_n = st_q ? DONE : WAIT_R;
        else if (tmo)   state_n = DONE;
      end
      WAIT_R:  if (mem_rvalid || tmo) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign stall = accept | (state == REQ) | (state == WAIT_R);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      off_q      <= '0;
      st_q       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      memory_val <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_n;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      if (accept) begin
        off_q     <= off;
        st_q      <= req_is_store;
        mem_req   <= 1'b1;
        mem_we    <= req_is_store;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be;
        mem_wdata <= wd;
      end
      if (state == REQ && (mem_ready || tmo)) begin
        mem_req <= 1'b0;
      end
      if (state == WAIT_R && mem_rvalid) begin
        memory_val <= mem_rdata >> {off_q, 3'b000};
        load_valid <= 1'b1;
      end
      if (tmo_hit) begin
        bus_err <= 1'b1;
        if (!st_q) memory_val <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: queued bus and load
// expectations checked by a monitor against a scripted bus.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  fn3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] memory_val;
  logic        load_valid;
  logic        misalign_err;
  logic        bus_err;

  always #5 clk = ~clk;

  lsu_mem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_is_store(req_is_store),
    .fn3(fn3),
    .addr(addr),
    .wdata(wdata),
    .stall(stall),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .memory_val(memory_val),
    .load_valid(load_valid),
    .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] ld_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int rdy_delay = 0;
  int rv_delay  = 0;
  int rdy_cnt   = 0;
  int rv_cnt    = 0;
  bit rv_pend   = 1'b0;
  bit no_ready  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bus_t mk(input logic we, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
    bus_t b;
    b.we = we;
    b.a  = a;
    b.be = be;
    b.wd = wd;
    return b;
  endfunction

  // scripted bus slave: ready after rdy_delay REQ cycles,
  // read data rv_delay cycles after the acceptance cycle
  always begin
    @(negedge clk);
    #2;
    mem_rvalid = 1'b0;
    if (mem_ready) begin
      mem_ready = 1'b0;
      if (!mem_we) begin
        rv_pend = 1'b1;
        rv_cnt  = 0;
      end
    end else if (mem_req && !no_ready) begin
      if (rdy_cnt == rdy_delay) begin
        mem_ready = 1'b1;
        rdy_cnt   = 0;
      end else begin
        rdy_cnt++;
      end
    end
    if (rv_pend) begin
      if (rv_cnt == rv_delay) begin
        mem_rvalid = 1'b1;
        rv_pend    = 1'b0;
      end else begin
        rv_cnt++;
      end
    end
  end

  always begin
    @(negedge clk);
    #4;
    if (mem_req) begin
      if (bus_q.size() == 0) begin
        chk("req_without_op", {63'b0, mem_req}, 64'd0);
      end else begin
        chk("bus_ctl", {mem_we, mem_addr, mem_be},
            {bus_q[0].we, bus_q[0].a, bus_q[0].be});
        if (bus_q[0].we) chk("bus_wdata", mem_wdata, bus_q[0].wd);
        if (mem_ready) void'(bus_q.pop_front());
      end
    end
    if (load_valid) begin
      if (ld_q.size() == 0)
        chk("load_valid_unexpected", {63'b0, load_valid}, 64'd0);
      else
        chk("memory_val", memory_val, ld_q.pop_front());
    end
  end

  task automatic op(input bit st, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] wd,
                    input int rd, input logic [31:0] rdat,
                    input int exp_stall, input string nm);
    int n;
    rdy_delay    = rd;
    rv_delay     = 0;
    mem_rdata    = rdat;
    req_valid    = 1'b1;
    req_is_store = st;
    fn3          = f;
    addr         = a;
    wdata        = wd;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    chk({nm, "_done_errs"}, {62'b0, misalign_err, bus_err}, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic nolaunch(input bit st, input logic [2:0] f,
                          input logic [31:0] a, input bit exp_err,
                          input string nm);
    req_valid    = 1'b1;
    req_is_store = st;
    fn3          = f;
    addr         = a;
    @(negedge clk);
    chk({nm, "_err"}, {63'b0, misalign_err}, 64'(exp_err));
    chk({nm, "_stall_req"}, {62'b0, stall, mem_req}, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_idle"}, {61'b0, stall, mem_req, misalign_err}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {59'b0, stall, mem_req, load_valid, bus_err, mem_we},
        64'd0);
    chk("rst_memory_val", memory_val, 64'd0);
    chk("rst_bus", {mem_addr, mem_be, 28'b0}, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    bus_q.push_back(mk(1'b0, 32'h0000_1000, 4'b1000, 32'h0));
    ld_q.push_back(32'h0000_00AB);
    op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'hAB00_0000, 3, "lb");

    bus_q.push_back(mk(1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_0000));
    op(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 3, 32'h0, 5, "sh");

    bus_q.push_back(mk(1'b1, 32'h0000_1000, 4'b0010, 32'h0000_5A00));
    op(1'b1, 3'b000, 32'h0000_1001, 32'hFFFF_FF5A, 0, 32'h0, 2, "sb");

    nolaunch(1'b0, 3'b010, 32'h0000_3001, 1'b1, "lw_mis");
    nolaunch(1'b1, 3'b001, 32'h0000_2003, 1'b1, "sh_mis");
    nolaunch(1'b1, 3'b011, 32'h0000_2000, 1'b0, "st_bad_fn3");

    bus_q.push_back(mk(1'b0, 32'h0000_4000, 4'b1100, 32'h0));
    ld_q.push_back(32'h0000_8001);
    op(1'b0, 3'b100, 32'h0000_4002, 32'h0, 0, 32'h8001_1234, 3, "lhu");
    bus_q.push_back(mk(1'b1, 32'h0000_4008, 4'b1111, 32'h1234_5678));
    op(1'b1, 3'b010, 32'h0000_4008, 32'h1234_5678, 0, 32'h0, 2, "sw");

    // reset while waiting for read data; data lands after reset
    bus_q.push_back(mk(1'b0, 32'h0000_5000, 4'b1111, 32'h0));
    rdy_delay    = 0;
    rv_delay     = 1;
    mem_rdata    = 32'hCAFE_F00D;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    fn3          = 3'b010;
    addr         = 32'h0000_5000;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      #3;
      if (mem_ready) break;
    end
    chk("rst_accept", {63'b0, mem_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("rst_drop_ctl", {61'b0, stall, load_valid, mem_req}, 64'd0);
    chk("rst_drop_val", memory_val, 64'd0);
    @(negedge clk);
    chk("rst_drop_ctl2", {62'b0, stall, load_valid}, 64'd0);
    chk("rst_drop_val2", memory_val, 64'd0);
    @(posedge clk);
    #1;
    rv_delay = 0;

    bus_q.push_back(mk(1'b0, 32'h0000_7000, 4'b0010, 32'h0));
    ld_q.push_back(32'h0011_2233);
    op(1'b0, 3'b101, 32'h0000_7001, 32'h0, 0, 32'h1122_3344, 3, "lb101");

    bus_q.push_back(mk(1'b0, 32'h0000_6000, 4'b1111, 32'h0));
    no_ready     = 1'b1;
    rdy_delay    = 0;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    fn3          = 3'b010;
    addr         = 32'h0000_6000;
`ifdef LSU_TIMEOUT_EN
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) break;
      k++;
    end
    chk("tmo_stall_cycles", 64'(k), 64'd5);
    chk("tmo_bus_err", {62'b0, bus_err, load_valid}, 64'd2);
    chk("tmo_memory_val", memory_val, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("tmo_bus_err_1cyc", {63'b0, bus_err}, 64'd0);
    void'(bus_q.pop_front());
    no_ready = 1'b0;
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_no_tmo", {62'b0, stall, bus_err}, 64'd2);
    end
    mem_rdata = 32'h0BAD_F00D;
    ld_q.push_back(32'h0BAD_F00D);
    no_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall) break;
    end
    chk("hold_release", {62'b0, stall, bus_err}, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`endif
    repeat (3) @(posedge clk);
    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    chk("ld_q_drained", 64'(ld_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store memory port sitting between the core's execute stage and the data memory bus, directly upstream of the load extension stage. Converts a byte/half/word load or store into one word-aligned bus transaction with byte enables and a valid/ready handshake. Stalls the core until the transaction completes. Returns read data shifted so the addressed byte/half sits at bits [7:0]/[15:0], ready for sign/zero extension downstream.

Parameters:
TIMEOUT_CYCLES, 255, bus wait limit in cycles; used only when LSU_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  core has a memory instruction this cycle; held until stall=0
req_is_store  in  1  1=store, 0=load
fn3  in  3  size code: loads 000/011 byte, 001/100 half, 010 word; stores 000 SB, 001 SH, 010 SW
addr  in  32  byte address
wdata  in  32  store data; bits [7:0]/[15:0]/[31:0] are used
stall  out  1  hold core PC and pipeline
mem_req  out  1  bus request valid
mem_ready  in  1  bus accepts the request this cycle
mem_we  out  1  write enable
mem_addr  out  32  {addr[31:2],2'b00}
mem_be  out  4  byte lanes
mem_wdata  out  32  lane-aligned store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
memory_val  out  32  lane-shifted load data, to the extension stage
load_valid  out  1  memory_val valid this cycle
misalign_err  out  1  misaligned access rejected
bus_err  out  1  bus timeout; tied 0 without LSU_TIMEOUT_EN

Behaviour:
- FSM states: IDLE, REQ, WAIT_R, DONE. Reset: state=IDLE; all registered outputs 0 (memory_val, load_valid, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata); timeout counter 0.
- off = addr[1:0]; size is byte, half or word per fn3.
- Misaligned means half with off[0]=1, or word with off!=0. In IDLE with req_valid=1 and misaligned: misalign_err=1 (combinational); no bus request; stall=0; stay in IDLE.
- Stores with fn3 outside 000-010: ignored. No request, stall=0, no error.
- Loads with fn3 101-111: treated as byte size.
- IDLE with a legal req_valid: stall=1 in the same cycle (combinational). Latch off, size, is_store, mem_addr, mem_be and mem_wdata. Next state is REQ.
- Byte enables: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111. Loads drive the same lanes with mem_we=0.
- Store data alignment: mem_wdata = size-masked wdata << (8*off).
- REQ: mem_req=1, and all bus outputs hold stable until the mem_ready cycle.
  - mem_ready with a store: go to DONE.
  - mem_ready with a load: go to WAIT_R.
  - mem_req drops in the cycle after acceptance.
- mem_rvalid is ignored outside WAIT_R; read data arrives at least 1 cycle after acceptance.
- WAIT_R: on mem_rvalid, memory_val <= mem_rdata >> (8*off); next state is DONE.
- DONE: held for one cycle.
  - stall=0, so the core retires the instruction.
  - load_valid=1 for loads only.
  - memory_val holds its value until the next load capture.
  - req_valid seen in DONE belongs to the retiring instruction and is ignored.
  - Next state is IDLE.
- Minimum latency:
  - Store: 2 stall cycles (IDLE, REQ with ready=1), then DONE.
  - Load: 3 stall cycles, then DONE.
- Reset asserted in any state: return to IDLE next edge; stall deasserts after that edge; any in-flight bus response is discarded.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REQ and increments each cycle spent in REQ or WAIT_R.
  - When it reaches TIMEOUT_CYCLES without the awaited mem_ready/mem_rvalid, go to DONE with bus_err=1 for that cycle.
  - For loads: memory_val=0 and load_valid=0.
- Undefined: no counter; bus_err constant 0; FSM waits indefinitely.

Test Plan:
- LB at addr 0x1003, mem_rdata 0xAB00_0000, ready on 1st REQ cycle, rvalid 1 cycle later -> mem_addr 0x1000, mem_be 4'b1000, memory_val 0x0000_00AB, load_valid high 1 cycle, stall high exactly 3 cycles.
- SH at addr 0x2002, wdata 0xDEAD_BEEF, ready delayed 3 cycles -> mem_be 4'b1100, mem_wdata 0xBEEF_0000, bus outputs stable across the wait, mem_we=1, stall released in DONE, load_valid=0.
- LW at addr 0x3001 -> misalign_err=1 same cycle, mem_req never asserted, stall=0, FSM stays IDLE.
- LHU (fn3=100) at 0x4002, rdata 0x8001_1234 -> memory_val 0x0000_8001; back-to-back SW at 0x4008 in the cycle after DONE -> mem_be 4'b1111.
- rst asserted during WAIT_R, rvalid arrives next cycle -> state IDLE, load_valid stays 0, memory_val 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with mem_ready never asserted -> bus_err=1 in the 5th post-IDLE cycle, stall drops, memory_val 0.
